// File: rtl/stride_addr_counter.sv
// Two-level strided address generator: addr = base + outer*pitch + inner*stride, paced by
// valid/ready. Optional early termination via abort_i when STRIDE_ADDR_COUNTER_ABORT_EN is defined.
module stride_addr_counter #(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned CNT_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_i,
  input  logic [ADDR_WIDTH-1:0] cfg_base_i,
  input  logic [ADDR_WIDTH-1:0] cfg_stride_i,
  input  logic [ADDR_WIDTH-1:0] cfg_pitch_i,
  input  logic [CNT_WIDTH-1:0]  cfg_inner_cnt_i,
  input  logic [CNT_WIDTH-1:0]  cfg_outer_cnt_i,
  input  logic                  ready_i,
  output logic                  valid_o,
  output logic [ADDR_WIDTH-1:0] addr_o,
  output logic [CNT_WIDTH-1:0]  inner_idx_o,
  output logic [CNT_WIDTH-1:0]  outer_idx_o,
  output logic                  last_inner_o,
  output logic                  last_o,
  output logic                  busy_o,
  output logic                  done_o
`ifdef STRIDE_ADDR_COUNTER_ABORT_EN
  ,
  input  logic                  abort_i
`endif
);

  localparam logic [CNT_WIDTH-1:0] CntOne  = 1;
  localparam logic [CNT_WIDTH-1:0] CntZero = '0;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  state_e                r_state, w_state_d;
  logic [ADDR_WIDTH-1:0] r_row_base, w_row_base_d;
  logic [ADDR_WIDTH-1:0] r_addr, w_addr_d;
  logic [ADDR_WIDTH-1:0] r_stride, w_stride_d;
  logic [ADDR_WIDTH-1:0] r_pitch, w_pitch_d;
  logic [CNT_WIDTH-1:0]  r_inner_cnt, w_inner_cnt_d;
  logic [CNT_WIDTH-1:0]  r_outer_cnt, w_outer_cnt_d;
  logic [CNT_WIDTH-1:0]  r_inner_idx, w_inner_idx_d;
  logic [CNT_WIDTH-1:0]  r_outer_idx, w_outer_idx_d;

  logic w_valid, w_xfer, w_last_inner, w_last, w_abort;

`ifdef STRIDE_ADDR_COUNTER_ABORT_EN
  assign w_abort = abort_i;
`else
  assign w_abort = 1'b0;
`endif

  // Flags decode registered state only, so nothing here depends on ready_i or start_i.
  assign w_valid      = (r_state == StRun);
  assign w_last_inner = w_valid && (r_inner_idx == (r_inner_cnt - CntOne));
  assign w_last       = w_last_inner && (r_outer_idx == (r_outer_cnt - CntOne));
  assign w_xfer       = w_valid && ready_i;

  assign valid_o      = w_valid;
  assign addr_o       = r_addr;
  assign inner_idx_o  = r_inner_idx;
  assign outer_idx_o  = r_outer_idx;
  assign last_inner_o = w_last_inner;
  assign last_o       = w_last;
  assign busy_o       = (r_state == StRun) || (r_state == StDone);
  assign done_o       = (r_state == StDone);

  always_comb begin
    w_state_d     = r_state;
    w_row_base_d  = r_row_base;
    w_addr_d      = r_addr;
    w_stride_d    = r_stride;
    w_pitch_d     = r_pitch;
    w_inner_cnt_d = r_inner_cnt;
    w_outer_cnt_d = r_outer_cnt;
    w_inner_idx_d = r_inner_idx;
    w_outer_idx_d = r_outer_idx;

    unique case (r_state)
      StIdle: begin
        if (start_i) begin
          w_row_base_d  = cfg_base_i;
          w_addr_d      = cfg_base_i;
          w_stride_d    = cfg_stride_i;
          w_pitch_d     = cfg_pitch_i;
          w_inner_cnt_d = cfg_inner_cnt_i;
          w_outer_cnt_d = cfg_outer_cnt_i;
          w_inner_idx_d = CntZero;
          w_outer_idx_d = CntZero;
          if ((cfg_inner_cnt_i == CntZero) || (cfg_outer_cnt_i == CntZero)) begin
            w_state_d = StDone;
          end else begin
            w_state_d = StRun;
          end
        end
      end
      StRun: begin
        if (w_xfer) begin
          if (w_last) begin
            w_state_d = StDone;
          end else if (w_last_inner) begin
            // Jump straight to the next row base so row boundaries cost no bubble.
            w_inner_idx_d = CntZero;
            w_outer_idx_d = r_outer_idx + CntOne;
            w_row_base_d  = r_row_base + r_pitch;
            w_addr_d      = r_row_base + r_pitch;
          end else begin
            w_inner_idx_d = r_inner_idx + CntOne;
            w_addr_d      = r_addr + r_stride;
          end
        end
        if (w_abort) begin
          w_state_d = StDone;
        end
      end
      StDone: begin
        w_state_d = StIdle;
      end
      default: begin
        w_state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= StIdle;
      r_row_base  <= '0;
      r_addr      <= '0;
      r_stride    <= '0;
      r_pitch     <= '0;
      r_inner_cnt <= '0;
      r_outer_cnt <= '0;
      r_inner_idx <= '0;
      r_outer_idx <= '0;
    end else begin
      r_state     <= w_state_d;
      r_row_base  <= w_row_base_d;
      r_addr      <= w_addr_d;
      r_stride    <= w_stride_d;
      r_pitch     <= w_pitch_d;
      r_inner_cnt <= w_inner_cnt_d;
      r_outer_cnt <= w_outer_cnt_d;
      r_inner_idx <= w_inner_idx_d;
      r_outer_idx <= w_outer_idx_d;
    end
  end

endmodule

// File: tb/tb_stride_addr_counter.sv
// Directed bench for stride_addr_counter: expected beats are queued from the address formula
// at launch and popped as the DUT transfers them. Abort checks need STRIDE_ADDR_COUNTER_ABORT_EN.
module tb_stride_addr_counter;

  logic        clk;
  logic        rst_n;
  logic        start_i;
  logic [15:0] cfg_base_i, cfg_stride_i, cfg_pitch_i;
  logic [7:0]  cfg_inner_cnt_i, cfg_outer_cnt_i;
  logic        ready_i;
  logic        valid_o;
  logic [15:0] addr_o;
  logic [7:0]  inner_idx_o, outer_idx_o;
  logic        last_inner_o, last_o, busy_o, done_o;
`ifdef STRIDE_ADDR_COUNTER_ABORT_EN
  logic        abort_i;
`endif

  typedef struct {
    logic [15:0] addr;
    logic [7:0]  ii;
    logic [7:0]  oi;
    logic        li;
    logic        l;
  } beat_t;

  beat_t q[$];
  int    n_cmp = 0;
  int    n_err = 0;

  stride_addr_counter #(
    .ADDR_WIDTH(16),
    .CNT_WIDTH (8)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start_i        (start_i),
    .cfg_base_i     (cfg_base_i),
    .cfg_stride_i   (cfg_stride_i),
    .cfg_pitch_i    (cfg_pitch_i),
    .cfg_inner_cnt_i(cfg_inner_cnt_i),
    .cfg_outer_cnt_i(cfg_outer_cnt_i),
    .ready_i        (ready_i),
    .valid_o        (valid_o),
    .addr_o         (addr_o),
    .inner_idx_o    (inner_idx_o),
    .outer_idx_o    (outer_idx_o),
    .last_inner_o   (last_inner_o),
    .last_o         (last_o),
    .busy_o         (busy_o),
    .done_o         (done_o)
`ifdef STRIDE_ADDR_COUNTER_ABORT_EN
    ,
    .abort_i        (abort_i)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_valid"}, {31'd0, valid_o}, 32'd0);
    chk({tag, "_busy"},  {31'd0, busy_o},  32'd0);
    chk({tag, "_done"},  {31'd0, done_o},  32'd0);
  endtask

  // Expected sequence straight from the closed-form address expression.
  task automatic push_expected(input logic [15:0] base, input logic [15:0] stride,
                               input logic [15:0] pitch, input int inner, input int outer);
    beat_t b;
    for (int o = 0; o < outer; o++) begin
      for (int i = 0; i < inner; i++) begin
        b.addr = base + 16'(o) * pitch + 16'(i) * stride;
        b.ii   = 8'(i);
        b.oi   = 8'(o);
        b.li   = (i == inner - 1);
        b.l    = (i == inner - 1) && (o == outer - 1);
        q.push_back(b);
      end
    end
  endtask

  task automatic run_seq(input logic [15:0] base, input logic [15:0] stride,
                         input logic [15:0] pitch, input int inner, input int outer,
                         input bit rand_ready, input bit hold_start);
    bit          nonempty;
    bit          held;
    bit          prev_last;
    int          cyc;
    beat_t       e;
    logic [15:0] h_addr;
    logic [7:0]  h_ii, h_oi;
    nonempty  = (inner != 0) && (outer != 0);
    held      = 1'b0;
    prev_last = 1'b0;
    cyc       = 0;
    q.delete();
    push_expected(base, stride, pitch, inner, outer);
    cfg_base_i      = base;
    cfg_stride_i    = stride;
    cfg_pitch_i     = pitch;
    cfg_inner_cnt_i = 8'(inner);
    cfg_outer_cnt_i = 8'(outer);
    start_i         = 1'b1;
    ready_i         = 1'b1;
    @(negedge clk);
    if (!hold_start) start_i = 1'b0;
    // Scramble config mid-run; the latched copy must be used.
    cfg_base_i   = 16'hDEAD;
    cfg_stride_i = 16'h0BAD;
    cfg_pitch_i  = 16'h0777;
    chk("first_valid", {31'd0, valid_o}, {31'd0, nonempty});
    chk("first_done",  {31'd0, done_o},  {31'd0, !nonempty});
    while (!done_o && cyc < 400) begin
      if (held) begin
        chk("hold_addr",  {16'd0, addr_o},     {16'd0, h_addr});
        chk("hold_inner", {24'd0, inner_idx_o}, {24'd0, h_ii});
        chk("hold_outer", {24'd0, outer_idx_o}, {24'd0, h_oi});
      end
      ready_i = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      prev_last = 1'b0;
      if (valid_o && ready_i) begin
        if (q.size() == 0) begin
          chk("extra_beat", 32'd1, 32'd0);
        end else begin
          e = q.pop_front();
          chk("beat_addr",       {16'd0, addr_o},       {16'd0, e.addr});
          chk("beat_inner",      {24'd0, inner_idx_o},  {24'd0, e.ii});
          chk("beat_outer",      {24'd0, outer_idx_o},  {24'd0, e.oi});
          chk("beat_last_inner", {31'd0, last_inner_o}, {31'd0, e.li});
          chk("beat_last",       {31'd0, last_o},       {31'd0, e.l});
        end
        prev_last = last_o;
      end
      held   = valid_o && !ready_i;
      h_addr = addr_o;
      h_ii   = inner_idx_o;
      h_oi   = outer_idx_o;
      @(negedge clk);
      cyc++;
    end
    start_i = 1'b0;
    ready_i = 1'b1;
    chk("done_seen",       {31'd0, done_o},    32'd1);
    chk("done_no_valid",   {31'd0, valid_o},   32'd0);
    chk("done_after_last", {31'd0, prev_last}, {31'd0, nonempty});
    chk("beats_left",      32'(q.size()),      32'd0);
    @(negedge clk);
    chk_idle("post_done");
  endtask

  initial begin
    rst_n           = 1'b0;
    start_i         = 1'b0;
    ready_i         = 1'b0;
    cfg_base_i      = '0;
    cfg_stride_i    = '0;
    cfg_pitch_i     = '0;
    cfg_inner_cnt_i = '0;
    cfg_outer_cnt_i = '0;
`ifdef STRIDE_ADDR_COUNTER_ABORT_EN
    abort_i         = 1'b0;
`endif
    repeat (2) @(negedge clk);
    chk_idle("reset");
    chk("reset_addr", {16'd0, addr_o}, 32'd0);
    chk("reset_last", {30'd0, last_inner_o, last_o}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic 3x2 sequence with ready held high.
    run_seq(16'h0100, 16'd2, 16'h0010, 3, 2, 1'b0, 1'b0);
    // Same config under random backpressure.
    run_seq(16'h0100, 16'd2, 16'h0010, 3, 2, 1'b1, 1'b0);
    run_seq(16'h0200, 16'd5, 16'h0040, 4, 3, 1'b1, 1'b0);
    // Empty runs.
    run_seq(16'h0300, 16'd1, 16'd1, 0, 5, 1'b0, 1'b0);
    run_seq(16'h0300, 16'd1, 16'd1, 3, 0, 1'b0, 1'b0);
    // start_i held throughout a run.
    run_seq(16'h0400, 16'd3, 16'h0100, 2, 3, 1'b0, 1'b1);
    // Address wrap.
    run_seq(16'hFFFE, 16'd1, 16'd0, 4, 1, 1'b0, 1'b0);
    run_seq(16'hFFF0, 16'h0008, 16'h0010, 2, 2, 1'b1, 1'b0);

    // Reset during beat 2 of a run.
    cfg_base_i      = 16'h0040;
    cfg_stride_i    = 16'd1;
    cfg_pitch_i     = 16'd0;
    cfg_inner_cnt_i = 8'd4;
    cfg_outer_cnt_i = 8'd1;
    ready_i         = 1'b1;
    start_i         = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_pre_addr", {16'd0, addr_o}, 32'h0042);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk_idle("rst_mid");
    chk("rst_mid_addr",  {16'd0, addr_o},      32'd0);
    chk("rst_mid_inner", {24'd0, inner_idx_o}, 32'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk_idle("rst_after");
    end

`ifdef STRIDE_ADDR_COUNTER_ABORT_EN
    begin
      int nx;
      nx = 0;
      cfg_base_i      = 16'h0000;
      cfg_stride_i    = 16'd1;
      cfg_pitch_i     = 16'h0010;
      cfg_inner_cnt_i = 8'd4;
      cfg_outer_cnt_i = 8'd4;
      ready_i         = 1'b1;
      start_i         = 1'b1;
      @(negedge clk);
      start_i = 1'b0;
      for (int k = 0; k < 5; k++) begin
        if (valid_o) nx++;
        if (k == 4) begin
          abort_i = 1'b1;
          chk("abort_beat5_addr", {16'd0, addr_o}, 32'h0010);
        end
        @(negedge clk);
      end
      abort_i = 1'b0;
      chk("abort_beats", 32'(nx), 32'd5);
      chk("abort_done",  {31'd0, done_o}, 32'd1);
      @(negedge clk);
      chk_idle("abort_idle");
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/stride_addr_counter.md
# stride_addr_counter

Run-time configurable two-level (outer × inner) address counter for the convolution datapath. It generates a strided, row-pitched address sequence: `addr = base + outer*pitch + inner*stride`. A start pulse launches each sequence, a valid/ready handshake paces it, and done pulses at the end. It replaces fixed-limit, fixed-offset counters in the convolution address path with one block whose limits, stride and pitch are latched per run.

## Interface
- `ADDR_WIDTH`, 16: width of base, stride, pitch and `addr_o`.
- `CNT_WIDTH`, 8: width of the inner/outer counts and indices.

Ports:
- `clk`  in  1  rising-edge clock; the only clock.
- `rst_n`  in  1  synchronous, active-low reset.
- `start_i`  in  1  launch request; honoured only in IDLE.
- `cfg_base_i`  in  ADDR_WIDTH  first address.
- `cfg_stride_i`  in  ADDR_WIDTH  increment per inner step.
- `cfg_pitch_i`  in  ADDR_WIDTH  increment per outer step, applied to the row base.
- `cfg_inner_cnt_i`  in  CNT_WIDTH  inner beats per row; 0 means an empty run.
- `cfg_outer_cnt_i`  in  CNT_WIDTH  number of rows; 0 means an empty run.
- `ready_i`  in  1  consumer accepts the current address.
- `valid_o`  out  1  `addr_o` and the indices are valid.
- `addr_o`  out  ADDR_WIDTH  current address.
- `inner_idx_o`, `outer_idx_o`  out  CNT_WIDTH  current indices.
- `last_inner_o`  out  1  current beat is the last of its row.
- `last_o`  out  1  current beat is the last of the run.
- `busy_o`  out  1  high in RUN and DONE.
- `done_o`  out  1  one-cycle end-of-run pulse.

## Operation
- Reset (`rst_n` low at a clock edge): state = IDLE. All outputs are 0, all internal registers are 0. This applies from any state; an aborted run produces no `done_o`.
- States:
  - IDLE: waits for `start_i`.
  - RUN: emits beats.
  - DONE: lasts one cycle, then returns to IDLE.
- IDLE + `start_i`:
  - Latch all `cfg_*` inputs.
  - If either count is 0, go to DONE with no beats.
  - Otherwise go to RUN with `addr = row_base = base` and both indices 0.
- RUN: `valid_o = 1`. A beat transfers when `valid_o && ready_i`. With `ready_i` low, all outputs hold.
- On a transfer when not `last_inner_o`:
  - `inner_idx += 1`
  - `addr += stride`
- On a transfer with `last_inner_o` and not `last_o`:
  - `inner_idx = 0`
  - `outer_idx += 1`
  - `row_base += pitch`
  - `addr = row_base + pitch`, i.e. the new row base.
- On a transfer with `last_o`: go to DONE.
- Flag definitions:
  - `last_inner_o = valid_o && inner_idx == inner_cnt-1`
  - `last_o = last_inner_o && outer_idx == outer_cnt-1`
- Arithmetic: all address sums are modulo 2^ADDR_WIDTH and wrap silently. Indices never exceed count-1.
- `start_i` in RUN or DONE is ignored, not queued. Changes on `cfg_*` during a run have no effect.
- DONE: `done_o = 1`, `valid_o = 0`. Next state is IDLE.

## Timing
- `start_i` sampled at edge N leads to `valid_o = 1` from cycle N+1, with `addr_o = base`.
- With `ready_i` held high, a run emits one beat per cycle: inner×outer beats, no bubbles at row boundaries.
- `done_o` is high in the cycle after the `last_o` transfer. The earliest restart is `start_i` in the cycle after `done_o`.
- Empty run: `start_i` at edge N gives `done_o` in cycle N+1 and `valid_o` never asserts.
- All outputs are registered or decoded from registered state only. There is no combinational path from `ready_i` or `start_i` to any output.

## Configuration
- Macro: `STRIDE_ADDR_COUNTER_ABORT_EN`.
- Defined:
  - Adds port `abort_i` (in, 1).
  - `abort_i` high in RUN forces DONE on the next edge, with `done_o` pulsing as normal. A beat transferring in that same cycle still counts.
  - `abort_i` has no effect in IDLE or DONE.
- Undefined: the port does not exist and a run always completes all beats.

## Test plan
- Sequence with `ready_i` held 1:
  - Stimulus: base 0x100, stride 2, pitch 0x10, inner 3, outer 2.
  - Required response: addrs 0x100, 0x102, 0x104, 0x110, 0x112, 0x114 on consecutive cycles.
  - `last_inner_o` on the 3rd and 6th beats, `last_o` on the 6th, `done_o` one cycle later.
- Backpressure: same config with `ready_i` toggled randomly → identical address sequence. `addr_o` and the indices are stable while `valid_o && !ready_i`.
- Empty run and ignored restart:
  - inner 0, outer 5 → `done_o` one cycle after start and no `valid_o`.
  - `start_i` held high through a RUN → exactly one run executes.
- Wrap and reset:
  - ADDR_WIDTH 16, base 0xFFFE, stride 1, inner 4, outer 1 → 0xFFFE, 0xFFFF, 0x0000, 0x0001.
  - `rst_n` low during beat 2 → all outputs 0 the next cycle, no `done_o`, IDLE.
- Abort (macro defined): inner 4, outer 4, `abort_i` pulsed on beat 5 with `ready_i` = 1 → 5 beats transferred, `done_o` on the next cycle, then IDLE.
